mul_div_unit: RTL

Sequential signed multiply/divide unit in the datapath. It sits directly upstream of the bus multiplexer and produces the 64-bit result consumed through the Zhigh/Zlow bus sources. Operand A comes from the Y register and operand B from the bus. It runs a radix-2 Booth multiply or a non-restoring divide at one iteration per clock, then holds the result for the control sequencer to gate onto the bus.

---
 rtl/mul_div_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (non-restoring) unit.
// One iteration per clock; the 64-bit result is held on zhigh/zlow for the bus.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] zhigh,
  output logic [WIDTH-1:0] zlow,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             fix_ph;
  logic [WIDTH:0]   acc;    // Booth accumulator / partial remainder
  logic [WIDTH-1:0] q;      // multiplier / dividend-quotient shift register
  logic             qm1;
  logic [WIDTH:0]   bx;     // sign-extended b (mul) or |b| (div)
  logic [WIDTH-1:0] a_r;
  logic             op_r, dbz_r, neg_q, neg_r;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_sh, div_sum;

  always_comb begin
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
    case ({q[0], qm1})
      2'b01:   mul_sum = acc + bx;
      2'b10:   mul_sum = acc - bx;
      default: mul_sum = acc;
    endcase
    // Shift in the next dividend bit; a negative remainder adds the divisor back.
    div_sh  = {acc[WIDTH-1:0], q[WIDTH-1]};
    div_sum = acc[WIDTH] ? div_sh + bx : div_sh - bx;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      cnt         <= '0;
      fix_ph      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      zhigh       <= '0;
      zlow        <= '0;
      div_by_zero <= 1'b0;
      acc         <= '0;
      q           <= '0;
      qm1         <= 1'b0;
      bx          <= '0;
      a_r         <= '0;
      op_r        <= 1'b0;
      dbz_r       <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state       <= RUN;
          busy        <= 1'b1;
          cnt         <= '0;
          fix_ph      <= 1'b0;
          div_by_zero <= 1'b0;
          op_r        <= op;
          a_r         <= a;
          acc         <= '0;
          qm1         <= 1'b0;
          dbz_r       <= (b == '0);
          neg_q       <= a[WIDTH-1] ^ b[WIDTH-1];
          neg_r       <= a[WIDTH-1];
          q           <= op ? a_mag : a;
          bx          <= op ? {1'b0, b_mag} : {b[WIDTH-1], b};
        end
        RUN: begin
          if (op_r) begin
            acc <= div_sum;
            q   <= {q[WIDTH-2:0], ~div_sum[WIDTH]};
          end else begin
            acc <= {mul_sum[WIDTH], mul_sum[WIDTH:1]};
            q   <= {mul_sum[0], q[WIDTH-1:1]};
            qm1 <= q[0];
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            state <= FIX;
            cnt   <= '0;
          end
        end
        FIX: begin
          // Phase 0 restores a negative remainder; phase 1 applies signs and publishes.
          if (!fix_ph) begin
            fix_ph <= 1'b1;
            if (op_r && acc[WIDTH]) acc <= acc + bx;
          end else begin
            state <= DONE;
            done  <= 1'b1;
            if (!op_r) begin
              zhigh <= acc[WIDTH-1:0];
              zlow  <= q;
            end else if (dbz_r) begin
              zhigh       <= a_r;
              zlow        <= '1;
              div_by_zero <= 1'b1;
            end else begin
              zhigh <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
              zlow  <= neg_q ? -q : q;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
